// File: rtl/seq_gen.sv
// Serial frame generator: shifts a latched PAT_W-bit frame out MSB first, (reps+1) times per burst,
// with GAP idle cycles between frames and a one-cycle done pulse after the final frame.
module seq_gen #(
    parameter int unsigned           PAT_W   = 4,
    parameter logic [PAT_W-1:0]      PATTERN = PAT_W'(4'b0110),
    parameter int unsigned           GAP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             use_def_i,
    input  logic [PAT_W-1:0] pat_in_i,
    input  logic [3:0]       reps_i,
    input  logic             abort_i,
    output logic             x_o,
    output logic             x_vld_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       frame_cnt_o
);

    localparam int unsigned      BW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0]    BitMsb  = BW'(PAT_W - 1);
    localparam logic [3:0]       GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] frame_q, frame_d;
    logic [3:0]       rem_q, rem_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [3:0]       gap_q, gap_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Output registers hold the value for the cycle that state_d describes, so x/x_vld track
    // the state one-for-one without a combinational output path.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    frame_d = use_def_i ? PATTERN : pat_in_i;
                    rem_d   = reps_i;
                    cnt_d   = 4'd0;
                    bit_d   = BitMsb;
                    state_d = StShift;
                    x_d     = frame_d[PAT_W-1];
                    vld_d   = 1'b1;
                end
            end
            StShift: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                    x_d   = frame_q[bit_d];
                    vld_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                    if (rem_q != 4'd0) begin
                        rem_d = rem_q - 4'd1;
                        if (GAP > 0) begin
                            state_d = StGap;
                            gap_d   = GapLast;
                        end else begin
                            bit_d = BitMsb;
                            x_d   = frame_q[PAT_W-1];
                            vld_d = 1'b1;
                        end
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StGap: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (gap_q == 4'd0) begin
                    state_d = StShift;
                    bit_d   = BitMsb;
                    x_d     = frame_q[PAT_W-1];
                    vld_d   = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            frame_q <= '0;
            rem_q   <= 4'd0;
            bit_q   <= '0;
            gap_q   <= 4'd0;
            cnt_q   <= 4'd0;
            x_q     <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign x_o         = x_q;
    assign x_vld_o     = vld_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with GAP=1 and one with GAP=0 feeding a 0110 detector.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic       use_def = 1'b0;
    logic [3:0] pat_in = 4'd0;
    logic [3:0] reps = 4'd0;
    logic       abort = 1'b0;

    logic       x, x_vld, busy, done;
    logic [3:0] frame_cnt;
    logic       x0, x_vld0, busy0, done0;
    logic [3:0] frame_cnt0;

    int n_vec = 0;
    int n_err = 0;

    int         hits = 0;
    logic [3:0] det_sh = 4'd0;

    always #5 clk = ~clk;

    seq_gen #(.PAT_W(4), .PATTERN(4'b0110), .GAP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .use_def_i(use_def), .pat_in_i(pat_in),
        .reps_i(reps), .abort_i(abort), .x_o(x), .x_vld_o(x_vld), .busy_o(busy), .done_o(done),
        .frame_cnt_o(frame_cnt)
    );

    seq_gen #(.PAT_W(4), .PATTERN(4'b0110), .GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .use_def_i(use_def), .pat_in_i(pat_in),
        .reps_i(reps), .abort_i(abort), .x_o(x0), .x_vld_o(x_vld0), .busy_o(busy0),
        .done_o(done0), .frame_cnt_o(frame_cnt0)
    );

    // Clock-synchronous 0110 detector looped back from the GAP=0 instance.
    always @(posedge clk) begin
        det_sh <= {det_sh[2:0], x0};
        if ({det_sh[2:0], x0} == 4'b0110) hits <= hits + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({busy, done, x_vld, x, frame_cnt} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_dut: got %b want 00000000", {busy, done, x_vld, x, frame_cnt});
        end
        n_vec++;
        if ({busy0, done0, x_vld0, x0, frame_cnt0} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_dut0: got %b want 00000000",
                     {busy0, done0, x_vld0, x0, frame_cnt0});
        end
        rst_n = 1'b1;
        tick();
    endtask

    // {busy,done,x_vld,x} per cycle; pat_in is junk to prove PATTERN is used.
    task automatic test_default;
        logic [3:0] p;
        logic [3:0] e;
        p = 4'b0110;
        use_def = 1'b1;
        reps = 4'd0;
        pat_in = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) e = {1'b1, 1'b0, 1'b1, p[3-i]};
            else if (i == 4) e = 4'b1100;
            else e = 4'b0000;
            n_vec++;
            if ({busy, done, x_vld, x} !== e) begin
                n_err++;
                $display("FAIL default cyc %0d: got %b want %b", i, {busy, done, x_vld, x}, e);
            end
            if (i == 5) begin
                n_vec++;
                if (frame_cnt !== 4'd1) begin
                    n_err++;
                    $display("FAIL default_cnt: got %0d want 1", frame_cnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_burst_gap;
        logic [3:0] p;
        logic [3:0] e;
        int         j;
        p = 4'b1011;
        use_def = 1'b0;
        reps = 4'd2;
        pat_in = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            j = i % 5;
            if (i == 14) e = 4'b1100;
            else if (i == 15) e = 4'b0000;
            else if (j < 4) e = {1'b1, 1'b0, 1'b1, p[3-j]};
            else e = 4'b1000;
            n_vec++;
            if ({busy, done, x_vld, x} !== e) begin
                n_err++;
                $display("FAIL burst_gap cyc %0d: got %b want %b", i, {busy, done, x_vld, x}, e);
            end
            if (i == 4 || i == 15) begin
                n_vec++;
                if (frame_cnt !== ((i == 4) ? 4'd1 : 4'd3)) begin
                    n_err++;
                    $display("FAIL burst_cnt cyc %0d: got %0d want %0d", i, frame_cnt,
                             (i == 4) ? 1 : 3);
                end
            end
            // A second start mid-burst with a different frame must not disturb anything.
            if (i == 6) begin
                start = 1'b1;
                pat_in = 4'b0000;
                reps = 4'd0;
            end
            if (i == 7) start = 1'b0;
            tick();
        end
    endtask

    task automatic test_abort;
        logic [3:0] e;
        use_def = 1'b0;
        pat_in = 4'b1011;
        reps = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        // Cycle 6: second bit of frame 2 (bit value 0) is on x.
        n_vec++;
        if ({busy, x_vld, x} !== 3'b110) begin
            n_err++;
            $display("FAIL abort_pre: got %b want 110", {busy, x_vld, x});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if ({busy, done, x_vld, x, frame_cnt} !== 8'b0000_0001) begin
            n_err++;
            $display("FAIL abort_post: got %b want 00000001", {busy, done, x_vld, x, frame_cnt});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = {busy, done, x_vld, x};
            n_vec++;
            if (e !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_idle cyc %0d: got %b want 0000", i, e);
            end
        end
    endtask

    task automatic test_loopback;
        int h0;
        int done_at;
        int vld_cnt;
        use_def = 1'b1;
        reps = 4'd3;
        h0 = hits;
        done_at = -1;
        vld_cnt = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (x_vld0) vld_cnt++;
            if (done0) begin
                done_at = i;
                break;
            end
            tick();
        end
        tick();
        n_vec++;
        if (done_at != 16) begin
            n_err++;
            $display("FAIL loop_done_at: got %0d want 16", done_at);
        end
        n_vec++;
        if (vld_cnt != 16) begin
            n_err++;
            $display("FAIL loop_vld_cycles: got %0d want 16", vld_cnt);
        end
        n_vec++;
        if (hits - h0 != 4) begin
            n_err++;
            $display("FAIL loop_detect: got %0d want 4", hits - h0);
        end
        n_vec++;
        if (frame_cnt0 !== 4'd4) begin
            n_err++;
            $display("FAIL loop_cnt: got %0d want 4", frame_cnt0);
        end
    endtask

    task automatic test_saturate;
        int done_at;
        use_def = 1'b0;
        pat_in = 4'b1001;
        reps = 4'd15;
        done_at = -1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done0) begin
                done_at = i;
                break;
            end
            tick();
        end
        n_vec++;
        if (done_at != 64) begin
            n_err++;
            $display("FAIL sat_done_at: got %0d want 64", done_at);
        end
        n_vec++;
        if (frame_cnt0 !== 4'd15) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d want 15", frame_cnt0);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        logic [3:0] p;
        logic [3:0] e;
        use_def = 1'b0;
        pat_in = 4'b1011;
        reps = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, x_vld, x, frame_cnt} !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid: got %b want 00000000", {busy, done, x_vld, x, frame_cnt});
        end
        p = 4'b1101;
        pat_in = p;
        start = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release_busy: got %b want 0", busy);
        end
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) e = {1'b1, 1'b0, 1'b1, p[3-i]};
            else if (i == 4) e = 4'b1100;
            else e = 4'b0000;
            n_vec++;
            if ({busy, done, x_vld, x} !== e) begin
                n_err++;
                $display("FAIL rst_fresh cyc %0d: got %b want %b", i, {busy, done, x_vld, x}, e);
            end
            tick();
        end
        n_vec++;
        if (frame_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL rst_fresh_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] p;
        logic [3:0] e;
        int         m;
        p = 4'b0110;
        use_def = 1'b1;
        reps = 4'd0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            m = i % 6;
            if (m < 4) e = {1'b1, 1'b0, 1'b1, p[3-m]};
            else if (m == 4) e = 4'b1100;
            else e = 4'b0000;
            n_vec++;
            if ({busy, done, x_vld, x} !== e) begin
                n_err++;
                $display("FAIL b2b cyc %0d: got %b want %b", i, {busy, done, x_vld, x}, e);
            end
            if (i == 13) start = 1'b0;
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            tick();
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got busy %b want 0", busy);
        end
        abort = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({busy, done, x_vld, x} !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_start cyc %0d: got %b want 0000", i, {busy, done, x_vld, x});
            end
        end
        abort = 1'b0;
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_default();
        test_burst_gap();
        test_abort();
        test_loopback();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
